// File: rtl/ifft_dac_player_if.sv
// IFFT sample stream into the DAC playback buffer (AXI-stream style handshake).
interface ifft_dac_player_if #(
    parameter int IN_W = 16
) ();
    logic            s_tvalid;
    logic [IN_W-1:0] s_tdata;
    logic            s_tlast;
    logic            s_tready;

    modport master (output s_tvalid, s_tdata, s_tlast, input s_tready);
    modport slave  (input s_tvalid, s_tdata, s_tlast, output s_tready);
endinterface

// File: rtl/ifft_dac_player.sv
// Ping-pong playback buffer: IFFT real part -> shifted, reduced offset-binary
// DAC codes; the last complete frame is replayed on da_en, banks swap at a wrap.
// Optional feature macro: IFFT_PLAY_SAT_EN (saturate and flag clipping instead
// of wrapping to the low DA_W bits).
module ifft_dac_player #(
    parameter int IN_W   = 16,
    parameter int DA_W   = 10,
    parameter int LOG2_N = 12
) (
    input  logic              fft_clk,
    input  logic              sys_rst_n,
    ifft_dac_player_if.slave  s,
    input  logic [3:0]        shift,
    input  logic [LOG2_N:0]   play_len,
    input  logic              da_en,
    output logic [DA_W-1:0]   da_data,
    output logic              frame_done,
    output logic              ovf,
    output logic              playing
);
    localparam logic [DA_W-1:0]   MID   = {1'b1, {(DA_W-1){1'b0}}};
    localparam logic [LOG2_N:0]   N_LEN = {1'b1, {LOG2_N{1'b0}}};

    typedef enum logic {W_FILL, W_HOLD} w_state_t;
    typedef enum logic {R_MUTE, R_PLAY} r_state_t;

    w_state_t w_state, w_next;
    r_state_t r_state, r_next;

    logic [DA_W-1:0]          mem [2*N_LEN];
    logic                     rd_bank, pending, clip_w;
    logic [LOG2_N-1:0]        wr_addr, rd_addr;
    logic [LOG2_N:0]          len, len_eff;
    logic                     accept, wr_last, wrap, strobe_wrap, swap;
    logic signed [IN_W-1:0]   shifted;
    logic [DA_W-1:0]          red, code;
    logic                     clip;

    assign shifted = $signed(s.s_tdata) >>> shift;

`ifdef IFFT_PLAY_SAT_EN
    logic in_range;
    // in range when every bit above the DA_W-1 sign position matches the sign
    assign in_range = (shifted[IN_W-1:DA_W-1] == {(IN_W-DA_W+1){shifted[IN_W-1]}});
    assign clip     = ~in_range;
    assign red      = in_range ? shifted[DA_W-1:0] : (shifted[IN_W-1] ? MID : ~MID);
`else
    logic unused_hi;
    assign unused_hi = ^shifted[IN_W-1:DA_W];
    assign clip      = 1'b0;
    assign red       = shifted[DA_W-1:0];
`endif

    assign code    = {~red[DA_W-1], red[DA_W-2:0]};
    assign len_eff = (play_len == '0 || play_len > N_LEN) ? N_LEN : play_len;

    assign accept      = (w_state == W_FILL) && s.s_tvalid;
    assign wr_last     = accept && (s.s_tlast || (&wr_addr));
    assign wrap        = ({1'b0, rd_addr} == len - 1'b1);
    assign strobe_wrap = (r_state == R_PLAY) && da_en && wrap;
    // a frame completing on a wrap edge is not yet pending, so it waits a lap
    assign swap        = pending && ((r_state == R_MUTE) || strobe_wrap);

    // state registers for both FSMs
    always_ff @(posedge fft_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            w_state <= W_FILL;
            r_state <= R_MUTE;
        end else begin
            w_state <= w_next;
            r_state <= r_next;
        end
    end

    // next-state and state-decoded outputs
    always_comb begin
        w_next     = w_state;
        r_next     = r_state;
        s.s_tready = (w_state == W_FILL);
        playing    = (r_state == R_PLAY);
        case (w_state)
            W_FILL:  if (wr_last)    w_next = W_HOLD;
            W_HOLD:  if (frame_done) w_next = W_FILL;
            default: w_next = W_FILL;
        endcase
        case (r_state)
            R_MUTE:  if (pending) r_next = R_PLAY;
            default: r_next = R_PLAY;
        endcase
    end

    // frame buffer write port; contents need no reset
    always_ff @(posedge fft_clk) begin
        if (accept) mem[{~rd_bank, wr_addr}] <= code;
    end

    // pointers, bank select, swap bookkeeping and the DAC output register
    always_ff @(posedge fft_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            rd_bank    <= 1'b0;
            pending    <= 1'b0;
            clip_w     <= 1'b0;
            wr_addr    <= '0;
            rd_addr    <= '0;
            len        <= N_LEN;
            da_data    <= MID;
            frame_done <= 1'b0;
            ovf        <= 1'b0;
        end else begin
            frame_done <= swap;
            if (swap) begin
                rd_bank <= ~rd_bank;
                ovf     <= clip_w;
            end
            if (swap)         pending <= 1'b0;
            else if (wr_last) pending <= 1'b1;
            if (swap)                 clip_w <= 1'b0;
            else if (accept && clip)  clip_w <= 1'b1;
            if (wr_last)     wr_addr <= '0;
            else if (accept) wr_addr <= wr_addr + 1'b1;
            if (swap || strobe_wrap) len <= len_eff;
            if (r_state == R_MUTE) begin
                if (pending) rd_addr <= '0;
            end else if (da_en) begin
                da_data <= mem[{rd_bank, rd_addr}];
                rd_addr <= wrap ? '0 : rd_addr + 1'b1;
            end
        end
    end
endmodule

// File: tb/tb_ifft_dac_player.sv
// Randomized bench for ifft_dac_player with a frame-level playback model.
module tb_ifft_dac_player;
    localparam int IN_W = 16, DA_W = 10, LOG2_N = 12;
    localparam int N = 1 << LOG2_N, HALF = 1 << (DA_W - 1);

    logic              fft_clk = 0, sys_rst_n = 0, da_en = 0;
    logic [3:0]        shift = 0;
    logic [LOG2_N:0]   play_len = 0;
    logic [DA_W-1:0]   da_data;
    logic              frame_done, ovf, playing;

    ifft_dac_player_if #(.IN_W(IN_W)) s_if ();

    ifft_dac_player #(.IN_W(IN_W), .DA_W(DA_W), .LOG2_N(LOG2_N)) dut (
        .fft_clk(fft_clk), .sys_rst_n(sys_rst_n), .s(s_if), .shift(shift),
        .play_len(play_len), .da_en(da_en), .da_data(da_data),
        .frame_done(frame_done), .ovf(ovf), .playing(playing));

    always #5 fft_clk = ~fft_clk;

    int n_vec = 0, n_bad = 0, n_fd = 0;
    bit chk_on = 0;

    task automatic chk(input string tag, input longint got, input longint exp);
        n_vec++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s got=%0h exp=%0h @%0t", tag, got, exp, $time);
        end
    endtask

    // ---------------- reference model ----------------
    int  m_mem [2][N];
    bit  m_rb = 0, m_pend = 0, m_acc = 1, m_play = 0, m_ovf = 0, m_clip = 0, m_fd = 0, m_took = 0;
    int  m_idx = 0, m_len = N, m_wi = 0, m_da = HALF;
    int  cur_val = 0;
    bit  cur_valid = 0, cur_last = 0;

    function automatic int eff_len(input int pl);
        return (pl == 0 || pl > N) ? N : pl;
    endfunction

    function automatic int to_code(input int d, input int sh, output bit c);
        int y;
        y = d >>> sh;
        c = 0;
`ifdef IFFT_PLAY_SAT_EN
        if (y > HALF - 1) begin y = HALF - 1; c = 1; end
        else if (y < -HALF) begin y = -HALF; c = 1; end
        return y + HALF;
`else
        return ((y % (2 * HALF)) + 3 * HALF) % (2 * HALF);
`endif
    endfunction

    task automatic model_step();
        bit sw, done, c;
        int code;
        if (!sys_rst_n) begin
            m_rb = 0; m_pend = 0; m_acc = 1; m_play = 0; m_ovf = 0; m_clip = 0;
            m_fd = 0; m_took = 0; m_idx = 0; m_len = N; m_wi = 0; m_da = HALF;
            return;
        end
        sw = 0;
        if (!m_play) begin
            if (m_pend) begin sw = 1; m_idx = 0; end
        end else if (da_en) begin
            m_da = m_mem[m_rb][m_idx];
            if (m_idx == m_len - 1) begin
                m_idx = 0;
                m_len = eff_len(int'(play_len));
                if (m_pend) sw = 1;
            end else m_idx++;
        end
        m_took = m_acc && cur_valid;
        done = 0;
        if (m_took) begin
            code = to_code(cur_val, int'(shift), c);
            m_mem[m_rb ^ 1'b1][m_wi] = code;
            m_clip |= c;
            if (cur_last || m_wi == N - 1) begin done = 1; m_wi = 0; end
            else m_wi++;
        end
        if (!m_acc && m_fd) m_acc = 1;
        if (done) m_acc = 0;
        if (sw) begin
            m_rb ^= 1'b1; m_pend = 0; m_ovf = m_clip; m_clip = 0;
            m_len = eff_len(int'(play_len)); m_play = 1;
        end
        m_fd = sw;
        if (done) m_pend = 1;
    endtask

    initial forever begin
        @(posedge fft_clk or negedge sys_rst_n);
        model_step();
    end

    // continuous output comparison, away from the active edge
    initial forever begin
        @(negedge fft_clk);
        if (frame_done === 1'b1) n_fd++;
        if (chk_on && sys_rst_n) begin
            chk("da_data", da_data, m_da);
            chk("tready", s_if.s_tready, m_acc);
            chk("frame_done", frame_done, m_fd);
            chk("ovf", ovf, m_ovf);
            chk("playing", playing, m_play);
        end
    end

    // DAC strobe generator: fixed period, or random duty
    int da_period = 50, da_pct = 0, cyc = 0;
    initial forever begin
        @(negedge fft_clk);
        cyc++;
        da_en = (da_period > 0) ? (cyc % da_period == 0) : ($urandom_range(99) < da_pct);
    end

    // ---------------- stimulus ----------------
    int frame_data [N];

    task automatic present(input bit v, input int k, input bit l);
        cur_valid = v; cur_last = l;
        cur_val = frame_data[k];
        s_if.s_tvalid = v;
        s_if.s_tdata  = cur_val[IN_W-1:0];
        s_if.s_tlast  = l;
    endtask

    task automatic send_frame(input int n, input bit use_last, input int pct,
                              input bit sync_last, input int stop_at);
        int k = 0, guard = 0;
        bit v;
        forever begin
            if (k >= n || (stop_at > 0 && k >= stop_at)) break;
            v = ($urandom_range(99) < pct);
            if (sync_last && k == n - 1) v = m_play && (m_idx == m_len - 1);
            present(v, k, use_last && (k == n - 1));
            @(negedge fft_clk);
            if (m_took) k++;
            guard++;
            if (guard > 20000) begin chk("send_timeout", k, n); break; end
        end
        present(0, 0, 0);
    endtask

    task automatic wait_swap(input int budget, output int cnt);
        cnt = 0;
        forever begin
            @(negedge fft_clk);
            cnt++;
            if (frame_done === 1'b1) break;
            if (cnt > budget) begin chk("swap_timeout", 0, 1); break; end
        end
    endtask

    int cnt, fd0, e0, e1, neg;

    initial begin
        present(0, 0, 0);
        repeat (3) @(negedge fft_clk);
        sys_rst_n = 1;
        chk_on = 1;

        // idle after reset: muted at midscale
        repeat (200) @(negedge fft_clk);
        chk("mute_da", da_data, 'h200);
        chk("mute_play", playing, 0);
        chk("mute_rdy", s_if.s_tready, 1);

        // full ramp frame, ended by address N-1
        for (int k = 0; k < N; k++) frame_data[k] = k - 2048;
        shift = 2; play_len = 0; da_period = 0; da_pct = 70;
        fd0 = n_fd;
        send_frame(N, 0, 80, 0, 0);
        repeat (7000) @(negedge fft_clk);
        chk("ramp_fd", n_fd - fd0, 1);

        // clipping frame, short tlast frame
        frame_data[0] = 30000; frame_data[1] = -30000;
        for (int k = 2; k < 16; k++) frame_data[k] = int'($urandom_range(65535)) - 32768;
        shift = 0; play_len = 16; da_pct = 100;
        send_frame(16, 1, 80, 0, 0);
        wait_swap(9000, cnt);
        @(negedge fft_clk);
        neg = -30000;
`ifdef IFFT_PLAY_SAT_EN
        e0 = 'h3FF; e1 = 'h000;
        chk("sat_ovf", ovf, 1);
`else
        e0 = (30000 & 'h3FF) ^ 'h200; e1 = (neg & 'h3FF) ^ 'h200;
        chk("sat_ovf", ovf, 0);
`endif
        chk("sat_pos", da_data, e0);
        @(negedge fft_clk);
        chk("sat_neg", da_data, e1);
        repeat (40) @(negedge fft_clk);

        // 200-word frames, second one written mid-playback
        play_len = 200; shift = 3; da_pct = 60;
        for (int k = 0; k < 200; k++) frame_data[k] = int'($urandom_range(65535)) - 32768;
        send_frame(200, 1, 80, 0, 0);
        wait_swap(2000, cnt);
        repeat (50) @(negedge fft_clk);
        for (int k = 0; k < 200; k++) frame_data[k] = int'($urandom_range(65535)) - 32768;
        fd0 = n_fd;
        send_frame(200, 1, 90, 0, 0);
        chk("hold_rdy", s_if.s_tready, 0);
        wait_swap(2000, cnt);
        repeat (450) @(negedge fft_clk);
        chk("len200_fd", n_fd - fd0, 1);

        // last write lands on a wrap edge: swap deferred one full lap
        da_pct = 100;
        for (int k = 0; k < 200; k++) frame_data[k] = int'($urandom_range(65535)) - 32768;
        send_frame(200, 1, 100, 1, 0);
        wait_swap(1000, cnt);
        chk("coinc_gap", cnt, 200);
        repeat (450) @(negedge fft_clk);

        // reset in the middle of a full frame write
        play_len = 0; shift = 1; da_pct = 50;
        for (int k = 0; k < N; k++) frame_data[k] = int'($urandom_range(65535)) - 32768;
        send_frame(N, 0, 100, 0, 1000);
        chk("wr_at_1000", m_wi, 1000);
        #2 sys_rst_n = 0;
        #1;
        chk("rst_da", da_data, 'h200);
        chk("rst_rdy", s_if.s_tready, 1);
        chk("rst_fd", frame_done, 0);
        chk("rst_ovf", ovf, 0);
        chk("rst_play", playing, 0);
        @(negedge fft_clk);
        sys_rst_n = 1;
        fd0 = n_fd;
        send_frame(N, 0, 85, 0, 0);
        wait_swap(2000, cnt);
        repeat (9000) @(negedge fft_clk);
        chk("post_rst_fd", n_fd - fd0, 1);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end
endmodule
